sprite_linebuf_pp: RTL and testbench

Parametrised ping-pong sprite line buffer: the next generation of the sprite pixel output stage. It replaces the fixed 4bpp/8-bit-palette odd/even RAM pairs with two generic banks, selectable priority, shadow merging and clear-on-read. The sprite renderer writes opaque pixels into the back bank while the front bank is scanned out to the mixer at pixel rate. Both banks swap on each line start.

---
 rtl/sprite_lb_pkg.sv | 22 ++
 rtl/linebuf_dpram.sv | 34 +++
 rtl/sprite_linebuf_pp.sv | 214 +++++++++++++++++++++
 tb/tb_sprite_linebuf_pp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_lb_pkg.sv
// Shared types and entry layout helpers for the sprite ping-pong line buffer.
// An entry is {S, pal, pix}; pix == 0 marks the slot as empty.
package sprite_lb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } lb_state_e;

    function automatic int ent_w(input int pal_bits, input int pix_bits);
        return pal_bits + pix_bits + 1;
    endfunction

    function automatic int pal_lsb(input int pix_bits);
        return pix_bits;
    endfunction

    function automatic int s_pos(input int pal_bits, input int pix_bits);
        return pal_bits + pix_bits;
    endfunction

endpackage

// File: rtl/linebuf_dpram.sv
// Simple dual-port line RAM: one synchronous read port, one write port.
// Read-during-write to the same address returns the old contents.
module linebuf_dpram
    import sprite_lb_pkg::*;
#(
    parameter int DEPTH = 384,
    parameter int AW    = 9,
    parameter int DW    = 13
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sprite_linebuf_pp.sv
// Ping-pong sprite line buffer: renderer fills the back bank while the
// front bank is scanned out and cleared behind the read pointer.
module sprite_linebuf_pp
    import sprite_lb_pkg::*;
#(
    parameter int LINE_W     = 384,
    parameter int XW         = $clog2(LINE_W),
    parameter int PIX_BITS   = 4,
    parameter int PAL_BITS   = 8,
    parameter int PRIO_FIRST = 0
) (
    input  logic                         clk_24M,
    input  logic                         RES,
    input  logic                         ce_wr,
    input  logic                         ce_pix,
    input  logic                         LINE_START,
    input  logic                         FLIP,
    input  logic                         SHAD_EN,
    input  logic                         wr_en,
    input  logic [XW-1:0]                wr_x,
    input  logic [PIX_BITS-1:0]          wr_pix,
    input  logic [PAL_BITS-1:0]          wr_pal,
    input  logic                         wr_shadow,
    output logic [PAL_BITS+PIX_BITS-1:0] OB,
    output logic                         SHAD,
    output logic                         NCO0,
    output logic                         BANK,
    output logic                         BUSY
);

    localparam int EW = ent_w(PAL_BITS, PIX_BITS);
    localparam int SP = s_pos(PAL_BITS, PIX_BITS);
    localparam int CW = $clog2(LINE_W + 1);
    localparam logic [XW-1:0] LAST = XW'(LINE_W - 1);
    localparam logic [CW-1:0] CEND = CW'(LINE_W);

    lb_state_e r_state, w_state_nxt;
    logic [XW-1:0] r_clr_addr;

    logic          r_bank;
    logic [CW-1:0] r_cnt;
    logic          r_rd_vld;
    logic          r_rd_bank;
    logic [XW-1:0] r_rd_addr;
    logic          r_zero_ld;

    logic                r_s1_vld;
    logic                r_s1_bank;
    logic                r_s1_sh;
    logic [XW-1:0]       r_s1_x;
    logic [PIX_BITS-1:0] r_s1_pix;
    logic [PAL_BITS-1:0] r_s1_pal;

    logic [SP-1:0] r_ob;
    logic          r_shad;
    logic          r_nco;

    logic          w_run, w_acc, w_scan, w_eol;
    logic [XW-1:0] w_scan_addr;
    logic [EW-1:0] w_old, w_rd_ent, w_s1_data;
    logic          w_occ, w_s1_we;

    logic          w_re    [2];
    logic [XW-1:0] w_raddr [2];
    logic          w_we    [2];
    logic [XW-1:0] w_waddr [2];
    logic [EW-1:0] w_wdata [2];
    logic [EW-1:0] w_rdata [2];

    assign w_run  = (r_state == RUN);
    assign w_acc  = w_run & ce_wr & wr_en
                  & ({1'b0, wr_x} < (XW+1)'(LINE_W))
                  & (wr_shadow ? SHAD_EN : (wr_pix != '0));
    assign w_scan = w_run & ce_pix & ~LINE_START & (r_cnt < CEND);
    assign w_eol  = w_run & ce_pix & ~LINE_START & (r_cnt == CEND);
    assign w_scan_addr = FLIP ? (LAST - r_cnt[XW-1:0]) : r_cnt[XW-1:0];

    // State register
    always_ff @(posedge clk_24M) begin
        if (RES) r_state <= CLEAR;
        else     r_state <= w_state_nxt;
    end

    // Leave the clear sweep once the last address has been written
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == CLEAR && r_clr_addr == LAST) w_state_nxt = RUN;
    end

    // Clear sweep address
    always_ff @(posedge clk_24M) begin
        if (RES)        r_clr_addr <= '0;
        else if (!w_run) r_clr_addr <= r_clr_addr + 1'b1;
    end

    // Write stage s0: capture request and target (back) bank
    always_ff @(posedge clk_24M) begin
        if (RES) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_acc;
            if (w_acc) begin
                r_s1_bank <= ~r_bank;
                r_s1_x    <= wr_x;
                r_s1_pix  <= wr_pix;
                r_s1_pal  <= wr_pal;
                r_s1_sh   <= wr_shadow;
            end
        end
    end

    // Write stage s1: merge new pixel with the old entry
    always_comb begin
        w_old   = w_rdata[r_s1_bank];
        w_occ   = |w_old[PIX_BITS-1:0];
        w_s1_we = r_s1_vld & (r_s1_sh | (PRIO_FIRST == 0) | ~w_occ);
        if (r_s1_sh)
            w_s1_data = w_occ ? {1'b1, w_old[SP-1:0]}
                              : {1'b1, {(EW-1){1'b0}}};
        else
            w_s1_data = {w_old[SP], r_s1_pal, r_s1_pix};
    end

    // Scan-out control: bank swap, pixel counter, read issue
    always_ff @(posedge clk_24M) begin
        if (RES) begin
            r_bank    <= 1'b0;
            r_cnt     <= CEND;
            r_rd_vld  <= 1'b0;
            r_zero_ld <= 1'b0;
        end else begin
            r_rd_vld  <= w_scan;
            r_zero_ld <= w_eol;
            if (w_scan) begin
                r_rd_addr <= w_scan_addr;
                r_rd_bank <= r_bank;
                r_cnt     <= r_cnt + 1'b1;
            end
            if (w_run & ce_pix & LINE_START) begin
                r_bank <= ~r_bank;
                r_cnt  <= '0;
            end
        end
    end

    // Per-bank port muxing by role (front/back) and state
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_we[b]    = 1'b0;
            w_waddr[b] = '0;
            w_wdata[b] = '0;
            if (r_bank == 1'(b)) begin
                w_re[b]    = w_scan;
                w_raddr[b] = w_scan_addr;
            end else begin
                w_re[b]    = w_acc;
                w_raddr[b] = wr_x;
            end
            if (!w_run) begin
                w_we[b]    = 1'b1;
                w_waddr[b] = r_clr_addr;
            end else if (w_s1_we && r_s1_bank == 1'(b)) begin
                w_we[b]    = 1'b1;
                w_waddr[b] = r_s1_x;
                w_wdata[b] = w_s1_data;
            end else if (r_rd_vld && r_rd_bank == 1'(b)) begin
                w_we[b]    = 1'b1;
                w_waddr[b] = r_rd_addr;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        linebuf_dpram #(
            .DEPTH (LINE_W),
            .AW    (XW),
            .DW    (EW)
        ) u_ram (
            .clk     (clk_24M),
            .i_we    (w_we[g]),
            .i_waddr (w_waddr[g]),
            .i_wdata (w_wdata[g]),
            .i_re    (w_re[g]),
            .i_raddr (w_raddr[g]),
            .o_rdata (w_rdata[g])
        );
    end

    assign w_rd_ent = w_rdata[r_rd_bank];

    // Output register: load scanned entry, or zero past end of line
    always_ff @(posedge clk_24M) begin
        if (RES || !w_run) begin
            r_ob   <= '0;
            r_shad <= 1'b0;
            r_nco  <= 1'b0;
        end else if (r_rd_vld) begin
            r_ob   <= w_rd_ent[SP-1:0];
            r_shad <= w_rd_ent[SP];
            r_nco  <= |w_rd_ent[PIX_BITS-1:0];
        end else if (r_zero_ld) begin
            r_ob   <= '0;
            r_shad <= 1'b0;
            r_nco  <= 1'b0;
        end
    end

    assign OB   = r_ob;
    assign SHAD = r_shad;
    assign NCO0 = r_nco;
    assign BANK = r_bank;
    assign BUSY = ~w_run;

endmodule

// File: tb/tb_sprite_linebuf_pp.sv
// Directed bench for sprite_linebuf_pp: two instances (last-wins and
// first-wins priority) share stimulus; scanned lines are captured per x.
module tb_sprite_linebuf_pp;

    localparam int LW = 384;
    localparam int XW = 9;

    localparam int OP_W = 0;
    localparam int OP_L = 1;
    localparam int OP_R = 2;
    localparam int OP_C = 3;

    typedef struct {
        int    op;
        int    x;
        int    pix;
        int    pal;
        bit    sh;
        bit    shen;
        bit    flip;
        int    e0;
        int    e1;
        bit    es;
        string nm;
    } vec_t;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          ce_wr = 1'b0;
    logic          ce_pix = 1'b0;
    logic          lstart = 1'b0;
    logic          flip = 1'b0;
    logic          shen = 1'b0;
    logic          wr_en = 1'b0;
    logic [XW-1:0] wr_x = '0;
    logic [3:0]    wr_pix = '0;
    logic [7:0]    wr_pal = '0;
    logic          wr_sh = 1'b0;

    logic [11:0] ob0, ob1;
    logic        sh0, sh1, nc0, nc1;
    logic        bk0, bk1, busy0, busy1;

    int nvec = 0;
    int nfail = 0;

    int cap0 [LW];
    int cap1 [LW];
    bit caps0 [LW];
    bit caps1 [LW];
    bit capn0 [LW];
    bit capn1 [LW];
    int last_k;
    int ext0;
    int ext1;

    vec_t vq[$];

    always #5 clk = ~clk;

    sprite_linebuf_pp #(.PRIO_FIRST(0)) dut0 (
        .clk_24M(clk), .RES(res), .ce_wr(ce_wr), .ce_pix(ce_pix),
        .LINE_START(lstart), .FLIP(flip), .SHAD_EN(shen),
        .wr_en(wr_en), .wr_x(wr_x), .wr_pix(wr_pix), .wr_pal(wr_pal),
        .wr_shadow(wr_sh), .OB(ob0), .SHAD(sh0), .NCO0(nc0),
        .BANK(bk0), .BUSY(busy0)
    );

    sprite_linebuf_pp #(.PRIO_FIRST(1)) dut1 (
        .clk_24M(clk), .RES(res), .ce_wr(ce_wr), .ce_pix(ce_pix),
        .LINE_START(lstart), .FLIP(flip), .SHAD_EN(shen),
        .wr_en(wr_en), .wr_x(wr_x), .wr_pix(wr_pix), .wr_pal(wr_pal),
        .wr_shadow(wr_sh), .OB(ob1), .SHAD(sh1), .NCO0(nc1),
        .BANK(bk1), .BUSY(busy1)
    );

    function automatic vec_t mk(input int op, input int x, input int pix,
                                input int pal, input bit sh, input bit se,
                                input bit fl, input int e0, input int e1,
                                input bit es, input string nm);
        vec_t v;
        v.op = op; v.x = x; v.pix = pix; v.pal = pal;
        v.sh = sh; v.shen = se; v.flip = fl;
        v.e0 = e0; v.e1 = e1; v.es = es; v.nm = nm;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input int x, input int pix, input int pal,
                      input bit sh, input bit se);
        ce_wr = 1'b1; wr_en = 1'b1;
        wr_x = XW'(x); wr_pix = 4'(pix); wr_pal = 8'(pal);
        wr_sh = sh; shen = se;
        tick();
        ce_wr = 1'b0; wr_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic scan(input bit swap, input bit fl);
        int x;
        flip = fl;
        if (swap) begin
            ce_pix = 1'b1; lstart = 1'b1;
            tick();
            ce_pix = 1'b0; lstart = 1'b0;
            tick();
        end
        for (int k = 0; k < LW; k++) begin
            ce_pix = 1'b1;
            tick();
            ce_pix = 1'b0;
            tick();
            x = fl ? (LW - 1 - k) : k;
            cap0[x] = int'(ob0); cap1[x] = int'(ob1);
            caps0[x] = sh0; caps1[x] = sh1;
            capn0[x] = nc0; capn1[x] = nc1;
            if (k == LW - 1) last_k = int'(ob0);
        end
        ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
        tick();
        ext0 = int'(ob0);
        ext1 = int'(ob1);
        flip = 1'b0;
    endtask

    task automatic race(input int x, input int pix, input int pal);
        ce_pix = 1'b1; lstart = 1'b1;
        ce_wr = 1'b1; wr_en = 1'b1;
        wr_x = XW'(x); wr_pix = 4'(pix); wr_pal = 8'(pal);
        wr_sh = 1'b0;
        tick();
        ce_pix = 1'b0; lstart = 1'b0;
        ce_wr = 1'b0; wr_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic check(input vec_t v);
        bit en0, en1;
        en0 = (v.e0 & 15) != 0;
        en1 = (v.e1 & 15) != 0;
        nvec++;
        if (cap0[v.x] !== v.e0 || cap1[v.x] !== v.e1 ||
            caps0[v.x] !== v.es || caps1[v.x] !== v.es ||
            capn0[v.x] !== en0 || capn1[v.x] !== en1) begin
            nfail++;
            $display("FAIL %s x=%0d: OB %0h/%0h want %0h/%0h SHAD %b/%b want %b NCO0 %b/%b want %b/%b",
                     v.nm, v.x, cap0[v.x], cap1[v.x], v.e0, v.e1,
                     caps0[v.x], caps1[v.x], v.es,
                     capn0[v.x], capn1[v.x], en0, en1);
        end
    endtask

    initial begin
        int  n;
        bit  bad;

        // line A: back bank 1
        vq.push_back(mk(OP_W, 5, 5, 'h3A, 0, 0, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 10, 1, 'h11, 0, 0, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 10, 2, 'h22, 0, 0, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 10, 0, 'h55, 0, 0, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 20, 3, 'h7F, 0, 1, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 20, 0, 'h00, 1, 1, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 21, 0, 'h00, 1, 1, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 22, 9, 'h44, 0, 0, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 22, 0, 'h00, 1, 0, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 400, 6, 'h66, 0, 0, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_W, 383, 15, 'hAB, 0, 0, 0, 0, 0, 0, "wA"));
        vq.push_back(mk(OP_L, 0, 0, 0, 0, 0, 0, 0, 0, 0, "lineA"));
        vq.push_back(mk(OP_C, 5, 0, 0, 0, 0, 0, 'h3A5, 'h3A5, 0, "basic"));
        vq.push_back(mk(OP_C, 10, 0, 0, 0, 0, 0, 'h222, 'h111, 0, "prio"));
        vq.push_back(mk(OP_C, 20, 0, 0, 0, 0, 0, 'h7F3, 'h7F3, 1, "shad_opq"));
        vq.push_back(mk(OP_C, 21, 0, 0, 0, 0, 0, 0, 0, 1, "shad_empty"));
        vq.push_back(mk(OP_C, 22, 0, 0, 0, 0, 0, 'h449, 'h449, 0, "shad_off"));
        vq.push_back(mk(OP_C, 16, 0, 0, 0, 0, 0, 0, 0, 0, "x400_drop"));
        vq.push_back(mk(OP_C, 383, 0, 0, 0, 0, 0, 'hABF, 'hABF, 0, "x_last"));
        vq.push_back(mk(OP_C, 0, 0, 0, 0, 0, 0, 0, 0, 0, "x0_empty"));
        // line B: back bank 0, flipped scan
        vq.push_back(mk(OP_W, 0, 1, 'h5C, 0, 0, 0, 0, 0, 0, "wB"));
        vq.push_back(mk(OP_L, 0, 0, 0, 0, 0, 1, 0, 0, 0, "lineB"));
        vq.push_back(mk(OP_C, 0, 0, 0, 0, 0, 0, 'h5C1, 'h5C1, 0, "flip_x0"));
        vq.push_back(mk(OP_C, 5, 0, 0, 0, 0, 0, 0, 0, 0, "bankB_x5"));
        // line C: bank 1 again, cleared by line A scan
        vq.push_back(mk(OP_L, 0, 0, 0, 0, 0, 0, 0, 0, 0, "lineC"));
        vq.push_back(mk(OP_C, 5, 0, 0, 0, 0, 0, 0, 0, 0, "cleared5"));
        vq.push_back(mk(OP_C, 10, 0, 0, 0, 0, 0, 0, 0, 0, "cleared10"));
        vq.push_back(mk(OP_C, 20, 0, 0, 0, 0, 0, 0, 0, 0, "cleared20"));
        // write racing the swap lands in the new front bank
        vq.push_back(mk(OP_R, 7, 2, 'h99, 0, 0, 0, 0, 0, 0, "race"));
        vq.push_back(mk(OP_C, 7, 0, 0, 0, 0, 0, 'h992, 'h992, 0, "race_x7"));
        vq.push_back(mk(OP_C, 0, 0, 0, 0, 0, 0, 0, 0, 0, "race_x0"));

        // reset: 3 clocks high, then BUSY must stay high LW clocks
        tick(); tick(); tick();
        res = 1'b0;
        n = 0;
        bad = 1'b0;
        while ((busy0 || busy1) && n < 2000) begin
            if (ob0 != 0 || ob1 != 0 || bk0 || bk1 || sh0 || nc0) bad = 1'b1;
            tick();
            n++;
        end
        chk("busy_len", n, LW);
        chk("rst_outs", int'(bad), 0);
        chk("bank_rst", int'(bk0), 0);

        foreach (vq[i]) begin
            case (vq[i].op)
                OP_W: wr(vq[i].x, vq[i].pix, vq[i].pal, vq[i].sh, vq[i].shen);
                OP_L: scan(1'b1, vq[i].flip);
                OP_R: begin
                    race(vq[i].x, vq[i].pix, vq[i].pal);
                    scan(1'b0, 1'b0);
                end
                default: check(vq[i]);
            endcase
            if (vq[i].nm == "lineA") begin
                chk("bank_A", int'(bk0), 1);
                chk("eol_zero", ext0, 0);
                chk("eol_zero1", ext1, 0);
            end
            if (vq[i].nm == "lineB") begin
                chk("flip_384th", last_k, 'h5C1);
                chk("bank_B", int'(bk0), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
